// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if -- request/result bundle between the display controller
// and the sequential binary-to-BCD converter.
//   start      : conversion request (master -> converter)
//   bin_in     : unsigned binary operand, sampled when start is accepted
//   busy       : conversion in progress
//   done       : one-cycle pulse when bcd_out/sig_digits update
//   bcd_out    : packed BCD result, digit 0 (ones) in bits [3:0]
//   sig_digits : number of significant digits (1..DIGITS)
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [2:0]            sig_digits;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  sig_digits
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output sig_digits
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock. Converts a WIDTH-bit register value into DIGITS
// packed BCD digits for the seven-segment display path.
//   clock : system clock, rising edge
//   reset : synchronous, active-high; aborts any conversion in flight
//   bus   : slave side of bin2bcd_seq_if (start/bin_in in,
//           busy/done/bcd_out/sig_digits out)
// A conversion accepted at edge k completes at edge k+WIDTH, where bcd_out
// and sig_digits update together and done pulses for one cycle. A new
// request may be accepted in that done cycle (back-to-back operation).
// DIGITS must satisfy 10**DIGITS > 2**WIDTH - 1, and DIGITS <= 7 so that
// sig_digits fits in three bits.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic         clock,
  input  logic         reset,
  bin2bcd_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   bit_cnt;
  logic               busy_r;
  logic               done_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [2:0]         sig_r;

  logic [BCD_W-1:0]   corrected;
  logic [BCD_W-1:0]   shifted;
  logic [2:0]         shifted_sig;
  logic               accept;

  // Add-3 correction: each digit is adjusted independently before the shift,
  // so a digit >= 5 cannot overflow past 9 once doubled.
  always_comb begin
    corrected = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Scratch after this cycle's shift; on the last iteration this is the result.
  assign shifted = {corrected[BCD_W-2:0], shift_reg[WIDTH-1]};

  // Highest nonzero digit index + 1; an all-zero result still shows one digit.
  always_comb begin
    shifted_sig = 3'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (shifted[4*i +: 4] != 4'd0) begin
        shifted_sig = 3'(i + 1);
      end
    end
  end

  // Requests are only honoured when not busy (IDLE or the done cycle).
  assign accept = bus.start && (state != SHIFT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= '0;
      sig_r     <= 3'd1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (accept) begin
            shift_reg <= bus.bin_in;
            scratch   <= '0;
            bit_cnt   <= CNT_W'(WIDTH);
            busy_r    <= 1'b1;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          scratch   <= shifted;
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            bcd_r  <= shifted;
            sig_r  <= shifted_sig;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.bcd_out    = bcd_r;
  assign bus.sig_digits = sig_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for done with a cycle budget; returns cycles waited and busy-high count.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busy_cycles++;
      tick();
      cycles++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] v,
                     input logic [19:0] exp_bcd, input logic [2:0] exp_sig);
    int n, nb;
    bus.bin_in = v;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    wait_done(n, nb);
    check({tag, "_latency"}, n, 16);
    check({tag, "_busy_cycles"}, nb, 16);
    check({tag, "_bcd"}, bus.bcd_out, exp_bcd);
    check({tag, "_sig"}, bus.sig_digits, exp_sig);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    tick();
    check({tag, "_done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    int n, nb, pulses;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd", bus.bcd_out, 0);
    check("rst_sig", bus.sig_digits, 1);
    reset = 1'b0;
    tick();

    run("zero", 16'h0000, 20'h00000, 3'd1);
    run("max",  16'hFFFF, 20'h65535, 3'd5);
    run("d1234", 16'h04D2, 20'h01234, 3'd4);
    run("d9",   16'h0009, 20'h00009, 3'd1);
    run("d100", 16'h0064, 20'h00100, 3'd3);

    // start while busy is ignored
    bus.bin_in = 16'h04D2;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (4) tick();
    bus.bin_in = 16'h0007;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.bin_in = 16'h0000;
    wait_done(n, nb);
    check("ign_latency", n + 5, 16);
    check("ign_bcd", bus.bcd_out, 20'h01234);
    check("ign_sig", bus.sig_digits, 4);
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.done) pulses++;
    end
    check("ign_extra_done", pulses, 0);
    check("hold_bcd", bus.bcd_out, 20'h01234);
    check("hold_busy", bus.busy, 0);

    // reset mid-conversion aborts
    bus.bin_in = 16'hFFFF;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (7) tick();
    check("abort_busy_before", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_bcd", bus.bcd_out, 0);
    check("abort_sig", bus.sig_digits, 1);
    pulses = 0;
    repeat (25) begin
      tick();
      if (bus.done || bus.busy) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // back-to-back: second request accepted during the done cycle
    bus.bin_in = 16'h0064;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    wait_done(n, nb);
    check("b2b_first_latency", n, 16);
    check("b2b_first_bcd", bus.bcd_out, 20'h00100);
    bus.bin_in = 16'h2710;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    check("b2b_busy", bus.busy, 1);
    check("b2b_done_fell", bus.done, 0);
    wait_done(n, nb);
    check("b2b_gap", n + 1, 17);
    check("b2b_second_bcd", bus.bcd_out, 20'h10000);
    check("b2b_second_sig", bus.sig_digits, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
It reads a 16-bit unsigned operand or result from the calculator's register file and produces packed BCD digits for the seven-segment display path.
A start/busy/done handshake lets the display controller request a conversion whenever a register value changes.

Parameters:
WIDTH, 16, binary input width in bits.
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  conversion request; sampled only when not busy
bin_in  input  WIDTH  unsigned binary value; sampled on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out and sig_digits update
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0]
sig_digits  output  3  count of significant digits, range 1..DIGITS; used for leading-zero blanking

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; bit counter and scratch registers clear.
  - busy=0, done=0, bcd_out=0, sig_digits=1.
  - Reset during SHIFT aborts the conversion. No done pulse is produced, and bcd_out is cleared to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: latch bin_in into the shift register, clear the BCD scratch, load counter=WIDTH, go to SHIFT.
  - busy=1 from edge k.
- SHIFT, one iteration per cycle:
  - Every scratch digit >=5 gets +3. Digits are corrected in parallel, each as a 4-bit add.
  - Then shift {scratch, shift_reg} left by 1, MSB of shift_reg entering scratch bit 0.
  - Decrement counter.
  - On the edge where counter reaches 0 (edge k+WIDTH): load the final scratch into bcd_out, compute sig_digits, go to DONE.
  - On that same edge busy drops to 0 and done rises to 1.
- Latency: start accepted at edge k, so done=1 during the cycle after edge k+WIDTH (16 cycles for the default).
- DONE (exactly one cycle, done=1, busy=0):
  - start=1: accepted as in IDLE (back-to-back); go to SHIFT, busy=1, done falls.
  - Otherwise go to IDLE.
- start while busy=1 is ignored. bin_in changes while busy have no effect.
- bcd_out and sig_digits hold their last values until the next done. They are never partially updated.
- sig_digits = index of the highest nonzero digit + 1. A result of 0 gives 1.
- No overflow is possible with the default parameters: max 65535 gives BCD 6,5,5,3,5.
- start held high continuously gives one conversion every WIDTH+1 cycles, each sampling bin_in at its accept edge.

Test Plan:
- bin_in=16'h0000, start pulse -> done 16 cycles later; bcd_out=20'h00000, sig_digits=1; busy high exactly 16 cycles.
- bin_in=16'hFFFF -> bcd_out=20'h65535, sig_digits=5.
- bin_in=16'h04D2 (1234) -> bcd_out=20'h01234, sig_digits=4. Then bin_in=16'h0009 -> bcd_out=20'h00009, sig_digits=1.
- Start 1234; at cycle 5 of busy, pulse start with bin_in=16'h0007 -> ignored; done at cycle 16 with bcd_out=20'h01234; only one done pulse.
- Start 65535; assert reset at cycle 8 of busy -> next cycle busy=0, done=0, bcd_out=0, sig_digits=1; no done pulse follows.
- Start 100 (16'h0064), then re-assert start with bin_in=16'h2710 (10000) during the done cycle -> first done bcd_out=20'h00100; second done exactly 17 cycles after the first with bcd_out=20'h10000, sig_digits=5.
